uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/byte_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// FSM encoding and frame constants for tx and rx.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int FRAME_BITS = 10;
    localparam int STOP_BITS  = 1;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock FIFO between the CPU bus and the serialiser.
// Head word is visible on dout without a read latency.
module byte_fifo #(
    parameter int WordSize  = 8,
    parameter int DepthLog2 = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WordSize-1:0]  din,
    output logic [WordSize-1:0]  dout,
    output logic [DepthLog2:0]   count,
    output logic                 full
);

    localparam int Depth = 1 << DepthLog2;

    logic [WordSize-1:0]  mem [Depth];
    logic [DepthLog2-1:0] rptr;
    logic [DepthLog2-1:0] wptr;

    assign dout = mem[rptr];
    assign full = (count == (DepthLog2+1)'(Depth));

    // Storage needs no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally; push+pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by the CPU IOload strobe.
// FIFO in a sub-module; baud timing, shifter and FSM here.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WordSize    = 8,
    parameter int DepthLog2   = 4,
    parameter int BaudDivisor = 104
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WordSize-1:0] databus,
    input  logic                IOload,
    output logic                txd,
    output logic                txfull,
    output logic                txbusy,
    output logic                overflow
);

    localparam int BW = $clog2(WordSize);
    localparam logic [15:0] RELOAD = 16'(BaudDivisor - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WordSize - 1);

    uart_state_t         state;
    logic [15:0]         baud;
    logic [BW-1:0]       bitn;
    logic [WordSize-1:0] shift;
    logic [WordSize-1:0] head;
    logic [DepthLog2:0]  count;
    logic                full;
    logic                wr;
    logic                pop;
    logic                push;

    assign wr  = ~IOload;
    assign pop = (count != '0) &&
                 ((state == IDLE) ||
                  (state == STOP && baud == '0));
    // A full FIFO still accepts when the head leaves this edge.
    assign push = wr && (!full || pop);

    assign txfull = full;
    assign txbusy = (state != IDLE) || (count != '0);

    byte_fifo #(
        .WordSize  (WordSize),
        .DepthLog2 (DepthLog2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (databus),
        .dout  (head),
        .count (count),
        .full  (full)
    );

    // Sticky flag for writes that found no room.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr && !push) begin
            overflow <= 1'b1;
        end
    end

    // Frame sequencer; txd is registered so the line never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            baud  <= '0;
            bitn  <= '0;
            shift <= '0;
            txd   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift <= head;
                        baud  <= RELOAD;
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud == '0) begin
                        baud  <= RELOAD;
                        bitn  <= '0;
                        txd   <= shift[0];
                        state <= DATA;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    if (baud == '0) begin
                        baud  <= RELOAD;
                        shift <= shift >> 1;
                        if (bitn == LAST_BIT) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bitn <= bitn + 1'b1;
                            txd  <= shift[1];
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                STOP: begin
                    if (baud == '0) begin
                        if (pop) begin
                            shift <= head;
                            baud  <= RELOAD;
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo.
// dut_a: depth 16, baud 4. dut_b: depth 4, baud 8.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic       iol_a = 1'b1;
    logic       iol_b = 1'b1;
    logic       txd_a, full_a, busy_a, ovf_a;
    logic       txd_b, full_b, busy_b, ovf_b;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .WordSize(8), .DepthLog2(4), .BaudDivisor(4)
    ) dut_a (
        .clk(clk), .reset(reset), .databus(data_a),
        .IOload(iol_a), .txd(txd_a), .txfull(full_a),
        .txbusy(busy_a), .overflow(ovf_a)
    );

    uart_tx_fifo #(
        .WordSize(8), .DepthLog2(2), .BaudDivisor(8)
    ) dut_b (
        .clk(clk), .reset(reset), .databus(data_b),
        .IOload(iol_b), .txd(txd_b), .txfull(full_b),
        .txbusy(busy_b), .overflow(ovf_b)
    );

    // Line receiver per DUT: samples each bit mid-period.
    logic       act [2];
    int         cnt [2];
    int         nfr [2];
    int         stop_bad [2];
    logic [7:0] sh [2];
    logic [7:0] rxb [2][16];

    always begin
        @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            logic t;
            int b;
            int idx;
            t = (d == 0) ? txd_a : txd_b;
            b = (d == 0) ? 4 : 8;
            if (reset) begin
                act[d] = 1'b0;
                cnt[d] = 0;
                nfr[d] = 0;
                stop_bad[d] = 0;
            end else if (!act[d]) begin
                if (t == 1'b0) begin
                    act[d] = 1'b1;
                    cnt[d] = 0;
                end
            end else begin
                cnt[d]++;
                if (cnt[d] % b == b / 2) begin
                    idx = cnt[d] / b;
                    if (idx >= 1 && idx <= 8) begin
                        sh[d][idx-1] = t;
                    end else if (idx == 9) begin
                        if (t != 1'b1) stop_bad[d]++;
                        if (nfr[d] < 16) rxb[d][nfr[d]] = sh[d];
                        nfr[d]++;
                        act[d] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act_v,
                       input logic [31:0] exp_v);
        compared++;
        if (act_v !== exp_v) begin
            mismatched++;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act_v, exp_v);
        end
    endtask

    // Checks txd_a for frame cycles k0..39 after the load edge.
    task automatic expect_frame(input string nm,
                                input logic [9:0] pat,
                                input int k0);
        for (int k = k0; k < 40; k++) begin
            tick();
            chk(nm, {31'b0, txd_a}, {31'b0, pat[k/4]});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];
    logic [7:0] s4 [6];
    logic [7:0] s5 [6];

    initial begin
        // frame = {stop, d7..d0, start}, sent bit 0 first
        vecs[0] = '{8'h55, 10'b1_01010101_0};
        vecs[1] = '{8'hA3, 10'b1_10100011_0};
        vecs[2] = '{8'h0F, 10'b1_00001111_0};
        vecs[3] = '{8'h00, 10'b1_00000000_0};
        vecs[4] = '{8'hFF, 10'b1_11111111_0};
        s4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        s5 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};

        // Reset then idle: line high, all flags low
        #1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_a", {28'b0, txd_a, busy_a, full_a, ovf_a},
                32'h8);
            chk("idle_b", {28'b0, txd_b, busy_b, full_b, ovf_b},
                32'h8);
        end

        // Single frames with exact bit timing
        for (int v = 0; v < 5; v++) begin
            data_a = vecs[v].data;
            iol_a = 1'b0;
            tick();
            iol_a = 1'b1;
            chk("frame_busy_set", {31'b0, busy_a}, 32'h1);
            expect_frame("frame_txd", vecs[v].frame, 0);
            chk("frame_busy_n40", {31'b0, busy_a}, 32'h1);
            tick();
            chk("frame_busy_n41", {31'b0, busy_a}, 32'h0);
        end

        // Back-to-back A3 then 0F, 80 clocks, no gap
        data_a = 8'hA3;
        iol_a = 1'b0;
        tick();
        data_a = 8'h0F;
        tick();
        iol_a = 1'b1;
        chk("b2b_start", {31'b0, txd_a}, 32'h0);
        expect_frame("b2b_f1", vecs[1].frame, 1);
        expect_frame("b2b_f2", vecs[2].frame, 0);
        chk("b2b_busy_n80", {31'b0, busy_a}, 32'h1);
        tick();
        chk("b2b_busy_n81", {31'b0, busy_a}, 32'h0);

        // Depth 4: six writes, sixth dropped
        do_reset();
        for (int i = 0; i < 6; i++) begin
            data_b = s4[i];
            iol_b = 1'b0;
            tick();
            if (i == 4) begin
                chk("ovf_full_n4", {31'b0, full_b}, 32'h1);
                chk("ovf_flag_n4", {31'b0, ovf_b}, 32'h0);
            end
        end
        iol_b = 1'b1;
        chk("ovf_flag_n5", {31'b0, ovf_b}, 32'h1);
        for (int i = 0; i < 450; i++) tick();
        chk("ovf_sticky", {31'b0, ovf_b}, 32'h1);
        chk("ovf_frames", nfr[1], 32'd5);
        chk("ovf_stopbits", stop_bad[1], 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("ovf_byte", {24'b0, rxb[1][i]}, {24'b0, s4[i]});
        end
        chk("ovf_idle", {30'b0, busy_b, full_b}, 32'h0);

        // Full FIFO, write on the edge where STOP completes
        do_reset();
        for (int i = 0; i < 5; i++) begin
            data_b = s5[i];
            iol_b = 1'b0;
            tick();
        end
        iol_b = 1'b1;
        for (int i = 0; i < 76; i++) tick();
        chk("edge_full_n80", {31'b0, full_b}, 32'h1);
        chk("edge_frames_n80", nfr[1], 32'd1);
        data_b = s5[5];
        iol_b = 1'b0;
        tick();
        iol_b = 1'b1;
        chk("edge_full_n81", {31'b0, full_b}, 32'h1);
        chk("edge_ovf_n81", {31'b0, ovf_b}, 32'h0);
        chk("edge_txd_n81", {31'b0, txd_b}, 32'h0);
        for (int i = 0; i < 420; i++) tick();
        chk("edge_frames", nfr[1], 32'd6);
        chk("edge_ovf_end", {31'b0, ovf_b}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk("edge_byte", {24'b0, rxb[1][i]}, {24'b0, s5[i]});
        end

        // Reset during data bit 3 of 0x81 with two queued
        do_reset();
        data_a = 8'h81;
        iol_a = 1'b0;
        tick();
        data_a = 8'h11;
        tick();
        data_a = 8'h22;
        tick();
        iol_a = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("rst_bit3", {31'b0, txd_a}, 32'h0);
        chk("rst_busy_pre", {31'b0, busy_a}, 32'h1);
        reset = 1'b1;
        tick();
        chk("rst_now", {29'b0, txd_a, busy_a, full_a},
            32'h4);
        reset = 1'b0;
        begin
            int lows;
            lows = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (txd_a != 1'b1 || busy_a != 1'b0) lows++;
            end
            chk("rst_quiet", lows, 32'd0);
        end
        chk("rst_frames", nfr[0], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
